// File: rtl/music_pkg.sv
// Shared definitions for the music playback blocks: sequencer state encoding,
// ROM entry field widths and the end-of-song marker.
package music_pkg;

    localparam int NOTE_W     = 6;
    localparam int DUR_W      = 6;
    localparam int ROM_DATA_W = 12;

    localparam logic [ROM_DATA_W-1:0] END_MARKER = 12'h000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT,
        DONE
    } state_t;

    // States in which note_player may be allowed to run.
    function automatic logic is_active_state(input state_t s);
        return (s == FETCH) || (s == LOAD) || (s == WAIT);
    endfunction

endpackage

// File: rtl/song_sequencer.sv
// Walks one song of the external song ROM and feeds each note/duration pair
// to note_player, handling pause/resume, end of song and song skipping.
module song_sequencer
    import music_pkg::*;
#(
    parameter int SONG_BITS = 2,
    parameter int NOTE_BITS = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic                           next_song,
    output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
    input  logic [ROM_DATA_W-1:0]          rom_data,
    output logic [NOTE_W-1:0]              note_to_load,
    output logic [DUR_W-1:0]               duration_to_load,
    output logic                           load_new_note,
    input  logic                           note_done,
    output logic                           play_enable,
    output logic [SONG_BITS-1:0]           song,
    output logic                           song_done
);

    state_t                         r_state;
    state_t                         w_next_state;
    logic [NOTE_BITS-1:0]           r_index;
    logic [NOTE_BITS-1:0]           w_next_index;
    logic [SONG_BITS-1:0]           r_song;
    logic [SONG_BITS-1:0]           w_song_plus1;
    logic [SONG_BITS+NOTE_BITS-1:0] r_rom_addr;
    logic [NOTE_W-1:0]              r_note;
    logic [DUR_W-1:0]               r_duration;
    logic                           r_load;
    logic                           r_play_enable;
    logic                           r_song_done;
    logic                           w_load;
    logic                           w_enter_done;
    logic                           w_enter_fetch;
    logic                           w_is_end;
    logic                           w_last_entry;

    assign w_is_end      = (rom_data == END_MARKER);
    assign w_last_entry  = &r_index;
    assign w_song_plus1  = r_song + 1'b1;
    assign w_enter_done  = (w_next_state == DONE) && (r_state != DONE);
    assign w_enter_fetch = (w_next_state == FETCH) && (r_state != FETCH);

    // next_song overrides every state transition, including a same-cycle
    // note_done or end marker.
    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        w_load       = 1'b0;
        if (next_song) begin
            w_next_state = IDLE;
            w_next_index = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (play) begin
                        w_next_state = FETCH;
                    end
                end
                FETCH: begin
                    w_next_state = LOAD;
                end
                LOAD: begin
                    if (w_is_end) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = WAIT;
                        w_load       = 1'b1;
                    end
                end
                WAIT: begin
                    if (note_done) begin
                        if (w_last_entry) begin
                            w_next_state = DONE;
                        end else begin
                            w_next_index = r_index + 1'b1;
                            w_next_state = FETCH;
                        end
                    end
                end
                DONE: begin
                    if (!play) begin
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
            if (w_next_state == DONE && r_state != DONE) begin
                w_next_index = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_index       <= '0;
            r_load        <= 1'b0;
            r_song_done   <= 1'b0;
            r_play_enable <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_index       <= w_next_index;
            r_load        <= w_load;
            r_song_done   <= w_enter_done;
            r_play_enable <= play && is_active_state(w_next_state);
        end
    end

    // The ROM address moves only when a fetch begins or the song changes,
    // so the end-of-song address stays visible after the song finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_song     <= '0;
            r_rom_addr <= '0;
        end else if (next_song) begin
            r_song     <= w_song_plus1;
            r_rom_addr <= {w_song_plus1, {NOTE_BITS{1'b0}}};
        end else if (w_enter_fetch) begin
            r_rom_addr <= {r_song, w_next_index};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_note     <= '0;
            r_duration <= '0;
        end else if (w_load) begin
            r_note     <= rom_data[DUR_W +: NOTE_W];
            r_duration <= rom_data[0 +: DUR_W];
        end
    end

    assign rom_addr         = r_rom_addr;
    assign note_to_load     = r_note;
    assign duration_to_load = r_duration;
    assign load_new_note    = r_load;
    assign play_enable      = r_play_enable;
    assign song             = r_song;
    assign song_done        = r_song_done;

endmodule
